// File: rtl/spi_pkg.sv
// Shared types and constants for the fabric-clocked SPI responder.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Flip-flops in each pin synchronizer chain.
    localparam int SYNC_STAGES = 2;

    // Minimum clk cycles per sclk period for reliable edge detection.
    localparam int MIN_OVERSAMPLE = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Pin synchronizer with a registered edge detector: level, rise and fall
// are all aligned to the last synchronizer stage.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   level_p1;

    // Shift the pin through the synchronizer and keep the previous synced level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0  <= {SYNC_STAGES{RST_VAL}};
            level_p1 <= RST_VAL;
        end else begin
            sync_p0  <= {sync_p0[SYNC_STAGES-2:0], din};
            level_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign level = sync_p0[SYNC_STAGES-1];
    assign rise  = level & ~level_p1;
    assign fall  = ~level & level_p1;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI responder running entirely on the system clock. SPI pins are
// oversampled; a frame is bracketed by load low, data is MSB first.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             load,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_dat,
    input  logic             tx_vld,
    output logic             tx_rdy,
    output logic             tx_udr,
    output logic [WIDTH-1:0] rx_dat,
    output logic             rx_vld,
    output logic             frm_err,
    output logic             busy,
    output logic [CNTW-1:0]  bit_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic load_lvl, load_rise, load_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_load (
        .clk(clk), .rst(rst), .din(load),
        .level(load_lvl), .rise(load_rise), .fall(load_fall)
    );

    // mosi is taken from the same stage as sclk so the sample lines up with the edge.
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_pins;
    assign unused_pins = ^{sclk_lvl, load_lvl, mosi_rise, mosi_fall};

    state_t           state, state_n;
    logic [WIDTH-1:0] tx_sh, tx_sh_n;
    logic [WIDTH-1:0] rx_sh, rx_sh_n;
    logic [WIDTH-1:0] hold_dat, hold_dat_n;
    logic             hold_full, hold_full_n;
    logic [WIDTH-1:0] frame_word;
    logic             miso_n, tx_udr_n, rx_vld_n, frm_err_n, busy_n;
    logic [WIDTH-1:0] rx_dat_n;
    logic [CNTW-1:0]  cnt_n;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next-state and datapath updates; holding-register capture is applied last
    // so a word offered in the frame-start cycle is kept for the following frame.
    always_comb begin
        state_n     = state;
        tx_sh_n     = tx_sh;
        rx_sh_n     = rx_sh;
        hold_dat_n  = hold_dat;
        hold_full_n = hold_full;
        frame_word  = '0;
        miso_n      = miso;
        tx_udr_n    = 1'b0;
        rx_vld_n    = 1'b0;
        frm_err_n   = 1'b0;
        rx_dat_n    = rx_dat;
        busy_n      = busy;
        cnt_n       = bit_cnt;

        case (state)
            IDLE: begin
                if (load_fall) begin
                    frame_word  = hold_full ? hold_dat : '0;
                    tx_sh_n     = frame_word;
                    miso_n      = frame_word[WIDTH-1];
                    tx_udr_n    = ~hold_full;
                    hold_full_n = 1'b0;
                    cnt_n       = '0;
                    busy_n      = 1'b1;
                    state_n     = SHIFT;
                end
            end
            SHIFT: begin
                if (load_rise) begin
                    state_n = DONE;
                end else begin
                    if (sclk_rise) begin
                        rx_sh_n = {rx_sh[WIDTH-2:0], mosi_s};
                        if (bit_cnt != CNT_MAX) cnt_n = bit_cnt + 1'b1;
                    end
                    if (sclk_fall) begin
                        tx_sh_n = {tx_sh[WIDTH-2:0], 1'b0};
                        miso_n  = tx_sh[WIDTH-2];
                    end
                end
            end
            DONE: begin
                if (bit_cnt == CNT_FULL) begin
                    rx_dat_n = rx_sh;
                    rx_vld_n = 1'b1;
                end else begin
                    frm_err_n = 1'b1;
                end
                busy_n  = 1'b0;
                miso_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (tx_vld && !hold_full) begin
            hold_full_n = 1'b1;
            hold_dat_n  = tx_dat;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_sh     <= '0;
            rx_sh     <= '0;
            hold_dat  <= '0;
            hold_full <= 1'b0;
            miso      <= 1'b0;
            tx_udr    <= 1'b0;
            rx_vld    <= 1'b0;
            frm_err   <= 1'b0;
            rx_dat    <= '0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            tx_sh     <= tx_sh_n;
            rx_sh     <= rx_sh_n;
            hold_dat  <= hold_dat_n;
            hold_full <= hold_full_n;
            miso      <= miso_n;
            tx_udr    <= tx_udr_n;
            rx_vld    <= rx_vld_n;
            frm_err   <= frm_err_n;
            rx_dat    <= rx_dat_n;
            busy      <= busy_n;
            bit_cnt   <= cnt_n;
        end
    end

    assign tx_rdy = ~hold_full;

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Clock-domain-synchronous SPI responder for the `spi_master` frame format: `load` framing, `sclk`, `mosi`/`miso`, MSB first, WIDTH bits per frame.
- Oversamples the SPI pins on the fabric clock, so its shift logic lives on `clk` rather than on `sclk`.
- Exchanges words with fabric logic through a valid/ready transmit holding register and a valid-pulse receive port.
- Replaces the sclk-clocked slave wherever the slave side must share the system clock.

Parameters:
- WIDTH, 13, bits per frame; 2..255.
- CNTW, 8, width of `bit_cnt`.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- sclk  in  1  SPI clock from master; idles low; asynchronous to `clk`.
- load  in  1  frame strobe from master; low = frame active; rising edge ends the frame.
- mosi  in  1  master-to-slave data.
- miso  out  1  slave-to-master data.
- tx_dat  in  WIDTH  word to send in a future frame.
- tx_vld  in  1  `tx_dat` valid.
- tx_rdy  out  1  holding register empty.
- tx_udr  out  1  one-clk pulse: frame started with empty holding register.
- rx_dat  out  WIDTH  last correctly received word.
- rx_vld  out  1  one-clk pulse: `rx_dat` updated.
- frm_err  out  1  one-clk pulse: frame ended with bit count ≠ WIDTH.
- busy  out  1  frame in progress.
- bit_cnt  out  CNTW  rising sclk edges seen in the current frame.

Behaviour:
- Reset (rst=0 at a clk edge): `miso`=0, `rx_dat`=0, `rx_vld`=0, `frm_err`=0, `tx_udr`=0, `tx_rdy`=1, `busy`=0, `bit_cnt`=0, holding register empty, state IDLE.
- Reset synchronizer values: `sclk` sync stages reset to 0; `load` sync stages reset to 0. A `load` already low at reset release therefore produces no falling edge; the block waits for a high→low transition.
- Input conditioning: `sclk`, `load` and `mosi` each pass through a 2-FF synchronizer plus a registered edge detector.
- Event latency: an action is taken 3 clk after the pin edge. `mosi` is sampled from the same synchronizer stage as `sclk`.
- Clock ratio: correct operation requires clk ≥ 8× sclk frequency (CLKFREQ/SPIFREQ ≥ 8 on the master side).
- Holding register:
  - `tx_vld`&`tx_rdy` captures `tx_dat`; `tx_rdy`=0 from the next cycle.
  - `tx_vld` with `tx_rdy`=0 is ignored.
  - Captures are permitted in any state.
- State IDLE, on `load` falling edge:
  - Holding full: shift-tx ← holding, holding emptied, `tx_rdy`=1 next cycle.
  - Holding empty: shift-tx ← 0, `tx_udr` pulses.
  - Same cycle as the `load` fall: `miso` ← new MSB, `bit_cnt`=0, `busy`=1 → SHIFT.
  - A simultaneous `tx_vld` capture is applied after the frame load, so that word goes to the next frame.
- State SHIFT:
  - sclk rising edge: shift-rx ← {shift-rx[WIDTH-2:0], mosi_s}; `bit_cnt` +1, saturating at 2^CNTW−1.
  - sclk falling edge: shift-tx shifts left, `miso` ← next bit. After WIDTH bits, `miso` ← 0.
  - load rising edge: → DONE. It has priority over an sclk edge in the same cycle; that sclk edge is discarded.
- State DONE, one cycle:
  - `bit_cnt`==WIDTH: `rx_dat` ← shift-rx, `rx_vld`=1.
  - Otherwise: `frm_err`=1 and `rx_dat` is unchanged.
  - In both cases `busy`=0, `miso`=0 → IDLE.
- IDLE ignores `sclk` edges and `load` rising edges. `bit_cnt` holds its final value until the next frame start.
- Reset mid-frame: returns immediately to reset values; the remainder of the frame is ignored.

Decomposition:
- Shared package `spi_pkg`:
  - state enum {IDLE, SHIFT, DONE};
  - SYNC_STAGES=2;
  - MIN_OVERSAMPLE=8.
- Sub-module `spi_sync_edge`: parameterised reset value; outputs level, rise and fall. Instantiated three times.

Test Plan:
1. WIDTH=13, master at 8:1 ratio. Preload `tx_dat`=0x1A5B; master sends 0x0F0F → `rx_dat`=0x0F0F with a single `rx_vld` pulse; master `dout`=0x1A5B; `frm_err`=0; `tx_rdy` rises 1 clk after frame start.
2. No `tx_vld` before the frame; master sends 0x1555 → `tx_udr` pulses once, master receives 0x0000, `rx_dat`=0x1555.
3. Short frame: 10 sclk pulses, then `load` rises → `frm_err` pulse, no `rx_vld`, `rx_dat` keeps the previous value, `bit_cnt`=10.
4. Load 0x0001 via `tx_vld` during frame 1 (tx 0x1FFF) → frame 1 returns 0x1FFF, frame 2 returns 0x0001; `tx_rdy` is low between capture and frame-2 start.
5. Assert `rst`=0 after bit 5 of a frame → all outputs at reset values next clk. The following full frame 0x1FFF gives `rx_dat`=0x1FFF and no `frm_err`.
6. Release reset with `load` held low, then toggle sclk → no `busy`, `rx_vld` or `frm_err` until a full `load` high→low→high frame occurs.
